// File: rtl/electronic_lock.sv
// Two-button combination lock: Moore FSM tracking how many code digits have been matched.
// State k (0..CODE_LEN-1) counts matched digits; CODE_LEN is UNLOCK and drives out.
module electronic_lock #(
  parameter int unsigned           CODE_LEN = 4,
  parameter logic [CODE_LEN-1:0]   CODE     = 4'b1101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b0,
  input  logic       b1,
  output logic       out,
  output logic [2:0] st
);

  typedef enum logic [2:0] {
    StIdle, St1, St2, St3, St4, St5, St6, St7
  } state_e;

  typedef enum logic [1:0] {
    PressNone, PressZero, PressOne, PressBad
  } press_e;

  localparam logic [2:0] CodeLenSt  = 3'(CODE_LEN);
  localparam state_e     StUnlock   = state_e'(CodeLenSt);
  localparam logic       FirstDigit = CODE[CODE_LEN-1];

  state_e state_q, state_d;
  press_e press;
  logic   digit;
  logic   exp_digit;

  always_comb begin
    press = PressNone;
    unique case ({b1, b0})
      2'b00:   press = PressNone;
      2'b01:   press = PressZero;
      2'b10:   press = PressOne;
      default: press = PressBad;
    endcase
  end

  assign digit = (press == PressOne);

  // E(k): digit expected once k digits are matched; MSB of CODE is entered first.
  always_comb begin
    exp_digit = 1'b0;
    for (int i = 0; i < int'(CODE_LEN); i++) begin
      if (state_q == state_e'(3'(i))) exp_digit = CODE[CODE_LEN-1-i];
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q > StUnlock) begin
      state_d = StIdle;
    end else begin
      unique case (press)
        PressNone: state_d = state_q;
        PressBad:  state_d = StIdle;
        default: begin
          if (state_q != StUnlock && digit == exp_digit) begin
            state_d = state_e'(state_q + 3'd1);
          end else begin
            // Mismatch (or press while unlocked) restarts, keeping the digit if it is F.
            state_d = (digit == FirstDigit) ? St1 : StIdle;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign out = (state_q == StUnlock);
  assign st  = state_q;

endmodule

// File: tb/tb_electronic_lock.sv
// Directed bench for electronic_lock with default code 1101: expected {st,out} pairs are
// queued as each step is driven and popped after the following rising edge.
module tb_electronic_lock;

  logic       clk;
  logic       rst;
  logic       b0;
  logic       b1;
  logic       out;
  logic [2:0] st;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q[$];

  electronic_lock #(
    .CODE_LEN(4),
    .CODE    (4'b1101)
  ) dut (
    .clk(clk),
    .rst(rst),
    .b0 (b0),
    .b1 (b1),
    .out(out),
    .st (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, queue the expected result, then check it after the edge.
  task automatic step(input logic ib0, input logic ib1, input logic irst,
                      input logic [2:0] exp_st, input string tag);
    logic [3:0] exp;
    logic [3:0] got;
    b0  = ib0;
    b1  = ib1;
    rst = irst;
    exp_q.push_back({exp_st, (exp_st == 3'd4)});
    @(posedge clk);
    #1;
    got = {st, out};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s: scoreboard empty, got st=%0d out=%0b", tag, st, out);
    end else begin
      exp = exp_q.pop_front();
      assert (got === exp) else begin
        failures++;
        $error("FAIL %s: got st=%0d out=%0b, expected st=%0d out=%0b",
               tag, got[3:1], got[0], exp[3:1], exp[0]);
      end
    end
  endtask

  task automatic press(input logic d, input logic [2:0] exp_st, input string tag);
    step(~d, d, 1'b0, exp_st, tag);
  endtask

  initial begin
    b0  = 1'b0;
    b1  = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // Reset has priority over a held b1
    step(1'b0, 1'b1, 1'b1, 3'd0, "reset0");
    step(1'b0, 1'b1, 1'b1, 3'd0, "reset1");
    press(1'b1, 3'd1, "rel_1");
    press(1'b1, 3'd2, "rel_2");
    press(1'b0, 3'd3, "rel_3");
    press(1'b1, 3'd4, "rel_unlock");

    // From UNLOCK a 0 (not F) goes to IDLE, then a continuous stream unlocks twice
    press(1'b0, 3'd0, "unlock_press0");
    press(1'b1, 3'd1, "stream_a1");
    press(1'b1, 3'd2, "stream_a2");
    press(1'b0, 3'd3, "stream_a3");
    press(1'b1, 3'd4, "stream_a4");
    press(1'b0, 3'd0, "stream_b0");
    press(1'b1, 3'd1, "stream_b1");
    press(1'b1, 3'd2, "stream_b2");
    press(1'b0, 3'd3, "stream_b3");
    press(1'b1, 3'd4, "stream_b4");

    // UNLOCK holds without presses; a 1 restarts at state 1
    step(1'b0, 1'b0, 1'b0, 3'd4, "unlock_hold0");
    step(1'b0, 1'b0, 1'b0, 3'd4, "unlock_hold1");
    press(1'b1, 3'd1, "unlock_press1");

    // Wrong-digit fallback
    press(1'b0, 3'd0, "s1_wrong0");
    press(1'b0, 3'd0, "idle_press0");
    press(1'b1, 3'd1, "fb_1");
    press(1'b1, 3'd2, "fb_2");
    press(1'b1, 3'd1, "fb_wrong1");
    press(1'b1, 3'd2, "fb_again2");

    // Idle hold at state 2
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 3'd2, "hold_s2");

    // Invalid press from state 3, and wrong 0 from state 3
    press(1'b0, 3'd3, "to_s3");
    step(1'b1, 1'b1, 1'b0, 3'd0, "invalid_s3");
    press(1'b1, 3'd1, "w_1");
    press(1'b1, 3'd2, "w_2");
    press(1'b0, 3'd3, "w_3");
    press(1'b0, 3'd0, "s3_wrong0");

    // Reset mid-entry, then a clean unlock
    press(1'b1, 3'd1, "mid_1");
    press(1'b1, 3'd2, "mid_2");
    press(1'b0, 3'd3, "mid_3");
    step(1'b0, 1'b1, 1'b1, 3'd0, "mid_reset");
    press(1'b1, 3'd1, "post_1");
    press(1'b1, 3'd2, "post_2");
    press(1'b0, 3'd3, "post_3");
    press(1'b1, 3'd4, "post_unlock");

    // Invalid press from UNLOCK
    step(1'b1, 1'b1, 1'b0, 3'd0, "invalid_unlock");

    if (exp_q.size() != 0) begin
      failures++;
      $error("FAIL leftover: got %0d queued entries, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
